// File: rtl/sec_encoder_location_clk.sv
`default_nettype none
// ============================================================================
// Module      : sec_encoder_location_clk
// Description : Sequential single-error-correcting encoder.
//               - Scans a latched data word LANES bits per cycle.
//               - Builds the Hamming syndrome by XOR-ing the codeword
//                 position of every set data bit.
//               - Packs data, check bits and an overall even-parity bit into
//                 a W_BITS-wide codeword.
//               Optional macro SEC_ENC_INJECT_EN adds a single-bit
//               error-injection port pair (inj_en / inj_pos) for generating
//               decoder test vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module sec_encoder_location_clk #(
    parameter int N_BITS = 31,
    parameter int W_BITS = 38,
    parameter int P_BITS = 6,
    parameter int LANES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] N,
`ifdef SEC_ENC_INJECT_EN
    input  logic              inj_en,
    input  logic [5:0]        inj_pos,
`endif
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [W_BITS-1:0] W
);

    // Number of SCAN cycles and the zero-padded width of the scanned word,
    // so that every lane index in every cycle stays inside the register.
    localparam int SCAN_CYCLES = (N_BITS + LANES - 1) / LANES;
    localparam int SCAN_W      = SCAN_CYCLES * LANES;
    localparam int IDX_W       = (SCAN_W > 1) ? $clog2(SCAN_W) : 1;
    localparam int CNT_W       = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0] LANE_STEP = IDX_W'(LANES);

    // Codeword position of data bit k: the k-th position >= 3 that is not a
    // power of two (powers of two hold the check bits, position 0 the
    // overall parity).
    function automatic logic [P_BITS-1:0] pos_of(input int k);
        int               n;
        logic [P_BITS-1:0] r;
        n = 0;
        r = '0;
        for (int p = 3; p < W_BITS; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == k) begin
                    r = P_BITS'(p);
                end
                n++;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_PACK = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state;
    logic [SCAN_W-1:0]   data;
    logic [P_BITS-1:0]   syn;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;
`ifdef SEC_ENC_INJECT_EN
    logic                inj_en_lat;
    logic [5:0]          inj_pos_lat;
    localparam logic [5:0] INJ_LIMIT = 6'(W_BITS);
`endif

    // Position lookup per scanned bit (padding bits map to position 0 and
    // therefore never disturb the syndrome).
    logic [P_BITS-1:0]   pos_tbl [SCAN_W];
    logic [P_BITS-1:0]   lane_term [LANES];
    logic [P_BITS-1:0]   syn_step;
    logic [W_BITS-1:1]   cw_body;
    logic [W_BITS-1:0]   clean_cw;
    logic [W_BITS-1:0]   pack_cw;

    // Data bits: fixed placement into the codeword and position table.
    for (genvar k = 0; k < N_BITS; k++) begin : g_pos
        localparam logic [P_BITS-1:0] POS = pos_of(k);
        assign pos_tbl[k]   = POS;
        assign cw_body[POS] = data[k];
    end

    // Padding slots beyond the data word contribute nothing.
    for (genvar k = N_BITS; k < SCAN_W; k++) begin : g_pad
        assign pos_tbl[k] = '0;
    end

    // Check bit i lives at codeword position 2^i.
    for (genvar i = 0; i < P_BITS; i++) begin : g_chk
        localparam int CPOS = 2 ** i;
        assign cw_body[CPOS] = syn[i];
    end

    // Per-lane syndrome contribution for the bits handled this cycle.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [IDX_W-1:0] OFF = IDX_W'(l);
        logic [IDX_W-1:0] lane_idx;
        assign lane_idx     = idx + OFF;
        assign lane_term[l] = data[lane_idx] ? pos_tbl[lane_idx] : '0;
    end

    // Fold all lane contributions into the running syndrome.
    always_comb begin
        syn_step = syn;
        for (int l = 0; l < LANES; l++) begin
            syn_step = syn_step ^ lane_term[l];
        end
    end

    // Overall parity makes the whole codeword even.
    assign clean_cw = {cw_body, ^cw_body};

    // Optional single-bit corruption applied after parity is computed.
    always_comb begin
        pack_cw = clean_cw;
`ifdef SEC_ENC_INJECT_EN
        if (inj_en_lat && (inj_pos_lat < INJ_LIMIT)) begin
            pack_cw[inj_pos_lat] = ~clean_cw[inj_pos_lat];
        end
`endif
    end

    // Control FSM with registered handshake outputs and codeword register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            W     <= '0;
            data  <= '0;
            syn   <= '0;
            idx   <= '0;
            cnt   <= '0;
`ifdef SEC_ENC_INJECT_EN
            inj_en_lat  <= 1'b0;
            inj_pos_lat <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        data  <= SCAN_W'(N);
                        syn   <= '0;
                        idx   <= '0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_SCAN;
`ifdef SEC_ENC_INJECT_EN
                        inj_en_lat  <= inj_en;
                        inj_pos_lat <= inj_pos;
`endif
                    end
                end
                S_SCAN: begin
                    syn <= syn_step;
                    idx <= idx + LANE_STEP;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state <= S_PACK;
                    end
                end
                S_PACK: begin
                    W     <= pack_cw;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    // start is deliberately not looked at here.
                    done  <= 1'b0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sec_encoder_location_clk.sv
`default_nettype none
// ============================================================================
// Module      : tb_sec_encoder_location_clk
// Description : Scoreboard bench for sec_encoder_location_clk (LANES=1 and
//               LANES=4 instances). Expected codewords come from a classic
//               parity-group Hamming model and are queued at launch time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sec_encoder_location_clk;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4;
    logic [30:0] n1, n4;
    logic        ready, busy, done;
    logic        ready4, busy4, done4;
    logic [37:0] w, w4;
`ifdef SEC_ENC_INJECT_EN
    logic        inj_en, inj_en4;
    logic [5:0]  inj_pos, inj_pos4;
`endif

    int checks   = 0;
    int failures = 0;
    logic [37:0] exp_q[$];

    always #5 clk = ~clk;

    sec_encoder_location_clk #(.LANES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .N(n1),
`ifdef SEC_ENC_INJECT_EN
        .inj_en(inj_en), .inj_pos(inj_pos),
`endif
        .ready(ready), .busy(busy), .done(done), .W(w)
    );

    sec_encoder_location_clk #(.LANES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .N(n4),
`ifdef SEC_ENC_INJECT_EN
        .inj_en(inj_en4), .inj_pos(inj_pos4),
`endif
        .ready(ready4), .busy(busy4), .done(done4), .W(w4)
    );

    // Reference: place data, then each check bit = parity of its group.
    function automatic logic [37:0] ref_cw(input logic [30:0] d);
        logic [37:0] c;
        int          k;
        int          par;
        c = '0;
        k = 0;
        for (int p = 3; p < 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            par = 0;
            for (int p = 3; p < 38; p++) begin
                if ((((p >> i) & 1) == 1) && c[p]) par ^= 1;
            end
            c[1 << i] = par[0];
        end
        c[0] = ^c[37:1];
        return c;
    endfunction

    // Location decoder syndrome: XOR of positions of all set bits.
    function automatic int loc_syn(input logic [37:0] cw);
        int s;
        s = 0;
        for (int p = 1; p < 38; p++) begin
            if (cw[p]) s ^= p;
        end
        return s;
    endfunction

    // Drive one start pulse into dut1 and queue its expected codeword.
    // Entered at a negedge with dut1 idle; returns at the negedge of cycle 1.
    task automatic launch(input logic [30:0] d);
        logic [37:0] e;
        e = ref_cw(d);
`ifdef SEC_ENC_INJECT_EN
        if (inj_en && (inj_pos < 6'd38)) e[inj_pos] = ~e[inj_pos];
`endif
        n1    = d;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for dut1 done; n is the cycle number since acceptance.
    task automatic wait_done1(output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (w !== 38'h0) begin failures++; $display("FAIL reset_w: got %h expected 0", w); end
        checks++; if (ready4 !== 1'b1 || w4 !== 38'h0) begin failures++; $display("FAIL reset_lanes4: ready=%b w=%h expected 1/0", ready4, w4); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_word;
        int n; logic [37:0] e;
        launch(31'h0);
        wait_done1(n);
        e = exp_q.pop_front();
        checks++; if (n !== 33) begin failures++; $display("FAIL zero_latency: got %0d expected 33", n); end
        checks++; if (w !== e) begin failures++; $display("FAIL zero_w: got %h expected %h", w, e); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL zero_ready_after: got %b expected 1", ready); end
    endtask

    task automatic test_single_bit;
        int n; logic [37:0] e;
        launch(31'h1);
        wait_done1(n);
        e = exp_q.pop_front();
        checks++; if (w !== 38'h00_0000_000F) begin failures++; $display("FAIL bit0_w_const: got %h expected 000000000f", w); end
        checks++; if (w !== e) begin failures++; $display("FAIL bit0_w_model: got %h expected %h", w, e); end
        @(negedge clk);
    endtask

    task automatic test_all_ones;
        int n; logic [37:0] e;
        launch(31'h7FFF_FFFF);
        wait_done1(n);
        e = exp_q.pop_front();
        checks++; if (w !== 38'h3F_FFFF_FFFC) begin failures++; $display("FAIL ones_w_const: got %h expected 3ffffffffc", w); end
        checks++; if (w !== e) begin failures++; $display("FAIL ones_w_model: got %h expected %h", w, e); end
        checks++; if (loc_syn(w) != 0 || (^w) !== 1'b0) begin failures++; $display("FAIL ones_decode: syn=%0d par=%b expected 0/0", loc_syn(w), ^w); end
        @(negedge clk);
    endtask

    task automatic test_random;
        int n; logic [37:0] e; logic [30:0] d;
        for (int t = 0; t < 4; t++) begin
            d = 31'($urandom);
            launch(d);
            wait_done1(n);
            e = exp_q.pop_front();
            checks++; if (n !== 33) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 33", t, n); end
            checks++; if (w !== e) begin failures++; $display("FAIL rand_w[%0d]: N=%h got %h expected %h", t, d, w, e); end
            checks++; if (loc_syn(w) != 0 || (^w) !== 1'b0) begin failures++; $display("FAIL rand_decode[%0d]: syn=%0d par=%b expected 0/0", t, loc_syn(w), ^w); end
            @(negedge clk);
        end
    endtask

    task automatic test_busy_start;
        int n; int extra; logic [37:0] e;
        launch(31'h1234_5678);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            if (n == 5) begin n1 = 31'h0ABC_DEF0; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        checks++; if (n !== 33) begin failures++; $display("FAIL busy_latency: got %0d expected 33", n); end
        checks++; if (w !== e) begin failures++; $display("FAIL busy_w: got %h expected %h", w, e); end
        // start during the DONE cycle must also be ignored
        n1 = 31'h7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL done_start: ready=%b busy=%b expected 1/0", ready, busy); end
        extra = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) extra++; end
        checks++; if (extra !== 0) begin failures++; $display("FAIL busy_extra_done: got %0d expected 0", extra); end
        checks++; if (w !== e) begin failures++; $display("FAIL busy_w_hold: got %h expected %h", w, e); end
    endtask

    task automatic test_reset_abort;
        int n; int extra;
        launch(31'h5555_AAAA);
        void'(exp_q.pop_back());
        for (n = 1; n < 10; n++) @(negedge clk);
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL abort_busy: busy=%b ready=%b expected 1/0", busy, ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (w !== 38'h0) begin failures++; $display("FAIL abort_w: got %h expected 0", w); end
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_ready: ready=%b busy=%b expected 1/0", ready, busy); end
        extra = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) extra++; end
        checks++; if (extra !== 0) begin failures++; $display("FAIL abort_done: got %0d expected 0", extra); end
    endtask

    task automatic test_back_to_back;
        int n; int gap; logic [37:0] e;
        n1 = 31'h0F0F_1234; start = 1'b1;
        exp_q.push_back(ref_cw(31'h0F0F_1234));
        @(negedge clk);
        n1 = 31'h7654_3210;
        exp_q.push_back(ref_cw(31'h7654_3210));
        wait_done1(n);
        e = exp_q.pop_front();
        checks++; if (n !== 33) begin failures++; $display("FAIL b2b_latency: got %0d expected 33", n); end
        checks++; if (w !== e) begin failures++; $display("FAIL b2b_w0: got %h expected %h", w, e); end
        gap = 0;
        do begin @(negedge clk); gap++; end while (done !== 1'b1 && gap < 100);
        start = 1'b0;
        e = exp_q.pop_front();
        checks++; if (gap !== 34) begin failures++; $display("FAIL b2b_gap: got %0d expected 34", gap); end
        checks++; if (w !== e) begin failures++; $display("FAIL b2b_w1: got %h expected %h", w, e); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_stop: got %b expected 1", ready); end
    endtask

    task automatic test_lanes4;
        int n; logic [37:0] e; logic [30:0] d;
        for (int t = 0; t < 3; t++) begin
            d = (t == 0) ? 31'h1 : 31'($urandom);
            e = ref_cw(d);
            n4 = d; start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            n = 1;
            while (done4 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            checks++; if (n !== 10) begin failures++; $display("FAIL l4_latency[%0d]: got %0d expected 10", t, n); end
            checks++; if (w4 !== e) begin failures++; $display("FAIL l4_w[%0d]: got %h expected %h", t, w4, e); end
            if (t == 0) begin
                checks++; if (w4 !== 38'h00_0000_000F) begin failures++; $display("FAIL l4_w_const: got %h expected 000000000f", w4); end
            end
            @(negedge clk);
        end
    endtask

`ifdef SEC_ENC_INJECT_EN
    task automatic test_inject;
        int n; logic [37:0] e;
        inj_en = 1'b1; inj_pos = 6'd5;
        launch(31'h0);
        wait_done1(n);
        e = exp_q.pop_front();
        checks++; if (w !== 38'h00_0000_0020) begin failures++; $display("FAIL inj5_w: got %h expected 0000000020", w); end
        @(negedge clk);
        inj_pos = 6'd40;
        launch(31'h0);
        wait_done1(n);
        e = exp_q.pop_front();
        checks++; if (w !== 38'h0) begin failures++; $display("FAIL inj40_w: got %h expected 0", w); end
        @(negedge clk);
        inj_pos = 6'd37;
        launch(31'h2AAA_5555);
        wait_done1(n);
        e = exp_q.pop_front();
        checks++; if (w !== e) begin failures++; $display("FAIL inj37_w: got %h expected %h", w, e); end
        checks++; if (n !== 33) begin failures++; $display("FAIL inj_latency: got %0d expected 33", n); end
        @(negedge clk);
        inj_en = 1'b0;
    endtask
`endif

    // Global bound so the run can never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; n1 = '0; n4 = '0;
`ifdef SEC_ENC_INJECT_EN
        inj_en = 1'b0; inj_pos = '0; inj_en4 = 1'b0; inj_pos4 = '0;
`endif
        test_reset;
        test_zero_word;
        test_single_bit;
        test_all_ones;
        test_random;
        test_busy_start;
        test_reset_abort;
        test_back_to_back;
        test_lanes4;
`ifdef SEC_ENC_INJECT_EN
        test_inject;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
